// File: rtl/evo_pmux_seq_pkg.sv
// Shared types for the pmux CSR command sequencer.
// Holds the FSM state encoding, the response status codes and the register-select bit positions.
// No logic lives here.
package evo_pmux_seq_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WPTR,
    ST_WREG,
    ST_RREQ,
    ST_RWAIT,
    ST_RESP
  } seq_state_t;

  // Response status codes driven on rsp_err
  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_MISMATCH = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_BAD_IDX  = 2'd3
  } seq_err_t;

  // Bit positions inside cmd_mask / pending mask
  localparam int SEL_DIR = 0;
  localparam int SEL_OUT = 1;
  localparam int SEL_EN  = 2;

endpackage

// File: rtl/evo_pmux_cfg_seq.sv
// Programs one pmux slot: writes WRADR, then DIR/OUT/EN as selected, and optionally reads them back to verify.
// Latency: with no stalls and all three registers selected, the writes occur 1..4 cycles after accept and the response follows in the next cycle.
// Backpressure: cmd_ready is high only in IDLE; waitrequest holds the current strobe, address and data stable.
module evo_pmux_cfg_seq
  import evo_pmux_seq_pkg::*;
#(
  parameter int CSR_AWIDTH  = 4,
  parameter int CSR_DWIDTH  = 32,
  parameter int PORT_DWIDTH = 32,
  parameter int MUX_WIDTH   = 16,
  parameter int WRADR_ADDR  = 2,
  parameter int DIR_ADDR    = 3,
  parameter int OUT_ADDR    = 4,
  parameter int EN_ADDR     = 5,
  parameter int RD_TIMEOUT  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_idx,
  input  logic [2:0]             cmd_mask,
  input  logic                   cmd_verify,
  input  logic [PORT_DWIDTH-1:0] cmd_dir,
  input  logic [PORT_DWIDTH-1:0] cmd_out,
  input  logic [PORT_DWIDTH-1:0] cmd_en,
  output logic                   rsp_valid,
  output logic [1:0]             rsp_err,
  output logic                   busy,
  output logic [CSR_AWIDTH-1:0]  avm_csr_address,
  output logic                   avm_csr_write,
  output logic [CSR_DWIDTH-1:0]  avm_csr_writedata,
  output logic                   avm_csr_read,
  input  logic [CSR_DWIDTH-1:0]  avm_csr_readdata,
  input  logic                   avm_csr_readdatavalid,
  input  logic                   avm_csr_waitrequest
);

  localparam int TW = $clog2(RD_TIMEOUT + 1);

  seq_state_t             r_state;
  seq_state_t             w_state_nxt;
  seq_err_t               r_err;
  seq_err_t               w_err_nxt;
  logic [3:0]             r_idx;
  logic [2:0]             r_mask;
  logic [2:0]             r_pend;
  logic                   r_verify;
  logic [PORT_DWIDTH-1:0] r_dir;
  logic [PORT_DWIDTH-1:0] r_out;
  logic [PORT_DWIDTH-1:0] r_en;
  logic [TW-1:0]          r_tmo;

  logic [2:0]             w_sel;
  logic [2:0]             w_rem;
  logic [CSR_AWIDTH-1:0]  w_sel_addr;
  logic [PORT_DWIDTH-1:0] w_sel_val;
  logic                   w_match;
  logic                   w_tmo_hit;

  // One-hot of the lowest pending register, DIR first, then OUT, then EN
  function automatic logic [2:0] f_lowest(input logic [2:0] pend);
    logic [2:0] sel;
    sel = '0;
    if (pend[SEL_DIR])      sel[SEL_DIR] = 1'b1;
    else if (pend[SEL_OUT]) sel[SEL_OUT] = 1'b1;
    else if (pend[SEL_EN])  sel[SEL_EN]  = 1'b1;
    return sel;
  endfunction

  assign w_sel     = f_lowest(r_pend);
  assign w_rem     = r_pend & ~w_sel;
  assign w_match   = (avm_csr_readdata[PORT_DWIDTH-1:0] == w_sel_val);
  assign w_tmo_hit = (r_tmo == TW'(RD_TIMEOUT - 1));

  // Address and captured value of the currently selected register
  always_comb begin
    w_sel_addr = CSR_AWIDTH'(EN_ADDR);
    w_sel_val  = r_en;
    if (w_sel[SEL_DIR]) begin
      w_sel_addr = CSR_AWIDTH'(DIR_ADDR);
      w_sel_val  = r_dir;
    end else if (w_sel[SEL_OUT]) begin
      w_sel_addr = CSR_AWIDTH'(OUT_ADDR);
      w_sel_val  = r_out;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and next-status selection
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (int'(cmd_idx) >= MUX_WIDTH) begin
            w_state_nxt = ST_RESP;
            w_err_nxt   = ERR_BAD_IDX;
          end else if (cmd_mask == 3'b000) begin
            w_state_nxt = ST_RESP;
            w_err_nxt   = ERR_OK;
          end else begin
            w_state_nxt = ST_WPTR;
          end
        end
      end
      ST_WPTR: if (!avm_csr_waitrequest) w_state_nxt = ST_WREG;
      ST_WREG: begin
        if (!avm_csr_waitrequest && w_rem == 3'b000) begin
          if (r_verify) begin
            w_state_nxt = ST_RREQ;
          end else begin
            w_state_nxt = ST_RESP;
            w_err_nxt   = ERR_OK;
          end
        end
      end
      ST_RREQ: if (!avm_csr_waitrequest) w_state_nxt = ST_RWAIT;
      ST_RWAIT: begin
        if (avm_csr_readdatavalid) begin
          if (!w_match) begin
            w_state_nxt = ST_RESP;
            w_err_nxt   = ERR_MISMATCH;
          end else if (w_rem == 3'b000) begin
            w_state_nxt = ST_RESP;
            w_err_nxt   = ERR_OK;
          end else begin
            w_state_nxt = ST_RREQ;
          end
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_RESP;
          w_err_nxt   = ERR_TIMEOUT;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Command capture, pending-mask bookkeeping and read timeout counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err    <= ERR_OK;
      r_idx    <= '0;
      r_mask   <= '0;
      r_pend   <= '0;
      r_verify <= 1'b0;
      r_dir    <= '0;
      r_out    <= '0;
      r_en     <= '0;
      r_tmo    <= '0;
    end else begin
      r_err <= w_err_nxt;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_idx    <= cmd_idx;
            r_mask   <= cmd_mask;
            r_pend   <= cmd_mask;
            r_verify <= cmd_verify;
            r_dir    <= cmd_dir;
            r_out    <= cmd_out;
            r_en     <= cmd_en;
          end
        end
        ST_WREG: begin
          // The last write reloads the pending set so readback walks the same registers
          if (!avm_csr_waitrequest)
            r_pend <= (w_rem == 3'b000 && r_verify) ? r_mask : w_rem;
        end
        ST_RREQ: begin
          if (!avm_csr_waitrequest) r_tmo <= '0;
        end
        ST_RWAIT: begin
          r_tmo <= r_tmo + 1'b1;
          if (avm_csr_readdatavalid && w_match) r_pend <= w_rem;
        end
        default: ;
      endcase
    end
  end

  // Bus strobes and handshake outputs decoded from the current state
  always_comb begin
    cmd_ready         = (r_state == ST_IDLE);
    busy              = (r_state != ST_IDLE);
    rsp_valid         = (r_state == ST_RESP);
    rsp_err           = (r_state == ST_RESP) ? r_err : ERR_OK;
    avm_csr_address   = '0;
    avm_csr_write     = 1'b0;
    avm_csr_writedata = '0;
    avm_csr_read      = 1'b0;
    case (r_state)
      ST_WPTR: begin
        avm_csr_write     = 1'b1;
        avm_csr_address   = CSR_AWIDTH'(WRADR_ADDR);
        avm_csr_writedata = CSR_DWIDTH'(r_idx);
      end
      ST_WREG: begin
        avm_csr_write     = 1'b1;
        avm_csr_address   = w_sel_addr;
        avm_csr_writedata = CSR_DWIDTH'(w_sel_val);
      end
      ST_RREQ: begin
        avm_csr_read    = 1'b1;
        avm_csr_address = w_sel_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_evo_pmux_cfg_seq.sv
// Directed bench for the pmux command sequencer with a small CSR slave model.
// The slave returns read data one cycle after a read transfer unless told to stay silent or corrupt OUT.
// The slot count is reduced to 12 so the 4-bit index can reach the out-of-range path.
module tb_evo_pmux_cfg_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_idx = '0;
  logic [2:0]  cmd_mask = '0;
  logic        cmd_verify = 1'b0;
  logic [31:0] cmd_dir = '0;
  logic [31:0] cmd_out = '0;
  logic [31:0] cmd_en = '0;
  logic        rsp_valid;
  logic [1:0]  rsp_err;
  logic        busy;
  logic [3:0]  avm_csr_address;
  logic        avm_csr_write;
  logic [31:0] avm_csr_writedata;
  logic        avm_csr_read;
  logic [31:0] avm_csr_readdata = '0;
  logic        avm_csr_readdatavalid = 1'b0;
  logic        avm_csr_waitrequest = 1'b0;

  evo_pmux_cfg_seq #(.MUX_WIDTH(12)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_idx               (cmd_idx),
    .cmd_mask              (cmd_mask),
    .cmd_verify            (cmd_verify),
    .cmd_dir               (cmd_dir),
    .cmd_out               (cmd_out),
    .cmd_en                (cmd_en),
    .rsp_valid             (rsp_valid),
    .rsp_err               (rsp_err),
    .busy                  (busy),
    .avm_csr_address       (avm_csr_address),
    .avm_csr_write         (avm_csr_write),
    .avm_csr_writedata     (avm_csr_writedata),
    .avm_csr_read          (avm_csr_read),
    .avm_csr_readdata      (avm_csr_readdata),
    .avm_csr_readdatavalid (avm_csr_readdatavalid),
    .avm_csr_waitrequest   (avm_csr_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [3:0]  addr;
    logic [31:0] data;
  } xfer_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = -1;
  int          rsp_cyc = -1;
  int          rsp_cnt = 0;
  int          rw_both = 0;
  logic [1:0]  rsp_err_s = '0;
  xfer_t       wr_q[$];
  xfer_t       rd_q[$];
  xfer_t       stb_q[$];
  logic [31:0] mem [16] = '{default: 32'h0};
  bit          no_rsp = 1'b0;
  bit          corrupt = 1'b0;
  bit          rd_flag = 1'b0;
  logic [31:0] rd_flag_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor and CSR slave model, evaluated mid-cycle
  always @(negedge clk) begin
    xfer_t x;
    x.cyc  = cyc;
    x.addr = avm_csr_address;
    x.data = avm_csr_writedata;
    if (cmd_valid && cmd_ready) acc_cyc = cyc;
    if (avm_csr_write && avm_csr_read) rw_both++;
    if (avm_csr_write) stb_q.push_back(x);
    if (avm_csr_write && !avm_csr_waitrequest) begin
      wr_q.push_back(x);
      mem[avm_csr_address] = avm_csr_writedata;
    end
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_cyc   = cyc;
      rsp_err_s = rsp_err;
    end
    avm_csr_readdatavalid = rd_flag && !no_rsp;
    avm_csr_readdata      = rd_flag_data;
    rd_flag      = avm_csr_read && !avm_csr_waitrequest;
    rd_flag_data = mem[avm_csr_address] ^ ((corrupt && avm_csr_address == 4'd4) ? 32'h1 : 32'h0);
    if (avm_csr_read && !avm_csr_waitrequest) rd_q.push_back(x);
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic nedge();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_q.delete();
    rd_q.delete();
    stb_q.delete();
    acc_cyc = -1;
    rsp_cyc = -1;
  endtask

  task automatic send_cmd(input logic [3:0] idx, input logic [2:0] mask, input logic verify,
                          input logic [31:0] dir, input logic [31:0] out, input logic [31:0] en);
    @(posedge clk);
    #1;
    cmd_idx    = idx;
    cmd_mask   = mask;
    cmd_verify = verify;
    cmd_dir    = dir;
    cmd_out    = out;
    cmd_en     = en;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output bit got);
    int c0;
    c0  = rsp_cnt;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      nedge();
      if (rsp_cnt != c0) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    nedge();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 2'd0) begin
      errors++; $display("FAIL reset_status got busy=%b rsp_valid=%b rsp_err=%0d exp 0/0/0", busy, rsp_valid, rsp_err); end
    checks++; if (avm_csr_write !== 1'b0 || avm_csr_read !== 1'b0 || avm_csr_address !== 4'd0 || avm_csr_writedata !== 32'd0) begin
      errors++; $display("FAIL reset_bus got wr=%b rd=%b addr=%0d data=%h exp all 0", avm_csr_write, avm_csr_read, avm_csr_address, avm_csr_writedata); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_write_seq();
    logic [3:0]  ea[4];
    logic [31:0] ed[4];
    bit got;
    ea = '{4'd2, 4'd3, 4'd4, 4'd5};
    ed = '{32'h5, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hFFFF0000};
    clear_log();
    send_cmd(4'd5, 3'b111, 1'b0, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hFFFF0000);
    wait_rsp(40, got);
    checks++; if (!got) begin errors++; $display("FAIL t1_rsp got none exp pulse"); end
    checks++; if (wr_q.size() != 4) begin errors++; $display("FAIL t1_wr_count got %0d exp 4", wr_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_q[i].addr !== ea[i] || wr_q[i].data !== ed[i] || wr_q[i].cyc != acc_cyc + 1 + i) begin
          errors++;
          $display("FAIL t1_wr%0d got (%0d,%h)@%0d exp (%0d,%h)@%0d", i, wr_q[i].addr, wr_q[i].data,
                   wr_q[i].cyc, ea[i], ed[i], acc_cyc + 1 + i);
        end
      end
    end
    checks++; if (rsp_cyc != acc_cyc + 5 || rsp_err_s !== 2'd0) begin
      errors++; $display("FAIL t1_rsp got err=%0d @%0d exp err=0 @%0d", rsp_err_s, rsp_cyc, acc_cyc + 5); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL t1_ready_in_resp got %b exp 0", cmd_ready); end
    nedge();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL t1_ready_after got %b exp 1", cmd_ready); end
    checks++; if (rd_q.size() != 0) begin errors++; $display("FAIL t1_no_reads got %0d exp 0", rd_q.size()); end
  endtask

  task automatic test_verify();
    bit got;
    clear_log();
    send_cmd(4'd5, 3'b111, 1'b1, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hFFFF0000);
    wait_rsp(60, got);
    checks++; if (!got || rsp_err_s !== 2'd0) begin errors++; $display("FAIL t2_ok_err got=%b err=%0d exp 1/0", got, rsp_err_s); end
    checks++; if (rd_q.size() != 3) begin errors++; $display("FAIL t2_ok_reads got %0d exp 3", rd_q.size()); end
    else begin
      checks++; if (rd_q[0].addr !== 4'd3 || rd_q[1].addr !== 4'd4 || rd_q[2].addr !== 4'd5) begin
        errors++; $display("FAIL t2_ok_addrs got %0d,%0d,%0d exp 3,4,5", rd_q[0].addr, rd_q[1].addr, rd_q[2].addr); end
    end
    corrupt = 1'b1;
    clear_log();
    send_cmd(4'd5, 3'b111, 1'b1, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hFFFF0000);
    wait_rsp(60, got);
    corrupt = 1'b0;
    checks++; if (!got || rsp_err_s !== 2'd1) begin errors++; $display("FAIL t2_mis_err got=%b err=%0d exp 1/1", got, rsp_err_s); end
    checks++; if (rd_q.size() != 2) begin errors++; $display("FAIL t2_mis_reads got %0d exp 2", rd_q.size()); end
    else begin
      checks++; if (rd_q[0].addr !== 4'd3 || rd_q[1].addr !== 4'd4) begin
        errors++; $display("FAIL t2_mis_addrs got %0d,%0d exp 3,4", rd_q[0].addr, rd_q[1].addr); end
    end
  endtask

  task automatic test_no_traffic();
    bit got;
    clear_log();
    send_cmd(4'd12, 3'b111, 1'b1, 32'h1, 32'h2, 32'h3);
    wait_rsp(10, got);
    checks++; if (!got || rsp_cyc != acc_cyc + 1 || rsp_err_s !== 2'd3) begin
      errors++; $display("FAIL t3_idx12 got=%b err=%0d @%0d exp err=3 @%0d", got, rsp_err_s, rsp_cyc, acc_cyc + 1); end
    checks++; if (stb_q.size() != 0 || rd_q.size() != 0) begin
      errors++; $display("FAIL t3_idx12_bus got wr=%0d rd=%0d exp 0/0", stb_q.size(), rd_q.size()); end
    clear_log();
    send_cmd(4'd15, 3'b001, 1'b0, 32'h1, 32'h2, 32'h3);
    wait_rsp(10, got);
    checks++; if (!got || rsp_err_s !== 2'd3 || stb_q.size() != 0) begin
      errors++; $display("FAIL t3_idx15 got=%b err=%0d strobes=%0d exp err=3 strobes=0", got, rsp_err_s, stb_q.size()); end
    clear_log();
    send_cmd(4'd3, 3'b000, 1'b1, 32'h1, 32'h2, 32'h3);
    wait_rsp(10, got);
    checks++; if (!got || rsp_cyc != acc_cyc + 1 || rsp_err_s !== 2'd0) begin
      errors++; $display("FAIL t3_mask0 got=%b err=%0d @%0d exp err=0 @%0d", got, rsp_err_s, rsp_cyc, acc_cyc + 1); end
    checks++; if (stb_q.size() != 0 || rd_q.size() != 0) begin
      errors++; $display("FAIL t3_mask0_bus got wr=%0d rd=%0d exp 0/0", stb_q.size(), rd_q.size()); end
  endtask

  task automatic test_waitrequest();
    bit got;
    clear_log();
    send_cmd(4'd11, 3'b001, 1'b0, 32'hDEADBEEF, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    avm_csr_waitrequest = 1'b1;
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1;
    avm_csr_waitrequest = 1'b0;
    wait_rsp(20, got);
    checks++; if (!got || rsp_cyc != acc_cyc + 6 || rsp_err_s !== 2'd0) begin
      errors++; $display("FAIL t4_rsp got=%b err=%0d @%0d exp err=0 @%0d", got, rsp_err_s, rsp_cyc, acc_cyc + 6); end
    checks++; if (wr_q.size() != 2) begin errors++; $display("FAIL t4_transfers got %0d exp 2", wr_q.size()); end
    else begin
      checks++; if (wr_q[0].data !== 32'd11 || wr_q[1].cyc != acc_cyc + 5) begin
        errors++; $display("FAIL t4_xfer got ptr=%h dir@%0d exp ptr=0000000b dir@%0d", wr_q[0].data, wr_q[1].cyc, acc_cyc + 5); end
    end
    checks++; if (stb_q.size() != 5) begin errors++; $display("FAIL t4_strobes got %0d exp 5", stb_q.size()); end
    else begin
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (stb_q[i].addr !== 4'd3 || stb_q[i].data !== 32'hDEADBEEF || stb_q[i].cyc != acc_cyc + 1 + i) begin
          errors++;
          $display("FAIL t4_hold%0d got (%0d,%h)@%0d exp (3,deadbeef)@%0d", i, stb_q[i].addr, stb_q[i].data,
                   stb_q[i].cyc, acc_cyc + 1 + i);
        end
      end
    end
  endtask

  task automatic test_timeout();
    bit got;
    no_rsp = 1'b1;
    clear_log();
    send_cmd(4'd7, 3'b001, 1'b1, 32'h12345678, 32'h0, 32'h0);
    wait_rsp(60, got);
    no_rsp = 1'b0;
    checks++; if (!got || rsp_err_s !== 2'd2) begin errors++; $display("FAIL t5_err got=%b err=%0d exp 1/2", got, rsp_err_s); end
    checks++; if (rd_q.size() != 1) begin errors++; $display("FAIL t5_reads got %0d exp 1", rd_q.size()); end
    else begin
      checks++; if (rsp_cyc != rd_q[0].cyc + 17) begin
        errors++; $display("FAIL t5_latency got rsp@%0d exp @%0d", rsp_cyc, rd_q[0].cyc + 17); end
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    int c0;
    clear_log();
    send_cmd(4'd4, 3'b111, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333);
    @(posedge clk);
    #1;
    c0  = rsp_cnt;
    rst = 1'b1;
    nedge();
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || avm_csr_write !== 1'b0 || avm_csr_address !== 4'd0 || avm_csr_writedata !== 32'd0) begin
      errors++; $display("FAIL t6_abort got ready=%b busy=%b wr=%b addr=%0d data=%h exp 1/0/0/0/0",
                         cmd_ready, busy, avm_csr_write, avm_csr_address, avm_csr_writedata); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) nedge();
    checks++; if (rsp_cnt != c0) begin errors++; $display("FAIL t6_no_rsp got %0d pulses exp 0", rsp_cnt - c0); end
    clear_log();
    send_cmd(4'd9, 3'b111, 1'b0, 32'h44444444, 32'h55555555, 32'h66666666);
    wait_rsp(40, got);
    checks++; if (!got || rsp_err_s !== 2'd0 || wr_q.size() != 4 || rsp_cyc != acc_cyc + 5) begin
      errors++; $display("FAIL t6_next got=%b err=%0d writes=%0d rsp@%0d exp 1/0/4 @%0d",
                         got, rsp_err_s, wr_q.size(), rsp_cyc, acc_cyc + 5); end
  endtask

  initial begin
    test_reset();
    test_write_seq();
    test_verify();
    test_no_traffic();
    test_waitrequest();
    test_timeout();
    test_reset_mid();
    checks++; if (rw_both != 0) begin errors++; $display("FAIL rw_exclusive got %0d overlap cycles exp 0", rw_both); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
